// File: rtl/uart_tx_serializer_if.sv
// Write side of the UART transmit buffer: byte push plus FIFO status.
// The APB interface is the master; the serializer is the slave.
interface uart_tx_serializer_if #(
    parameter int ADDR_W = 4
) ();
    logic              wr_en_i;
    logic [7:0]        wr_data_i;
    logic              tx_full_o;
    logic              tx_empty_o;
    logic [ADDR_W:0]   tx_level_o;
    logic              error_tx_detect;

    modport master (
        output wr_en_i,
        output wr_data_i,
        input  tx_full_o,
        input  tx_empty_o,
        input  tx_level_o,
        input  error_tx_detect
    );

    modport slave (
        input  wr_en_i,
        input  wr_data_i,
        output tx_full_o,
        output tx_empty_o,
        output tx_level_o,
        output error_tx_detect
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer
// clocked by the 16x oversample enable.
module uart_tx_serializer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       baud_tick_i,
    input  logic       TXen,
    uart_tx_serializer_if.slave bus,
    input  logic [3:0] number_data_send,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       stop_bit_twice,
    output logic       UART_TXD,
    output logic       tx_busy_o,
    output logic       TXdone
);
    localparam int TW = $clog2(OVERSAMPLE);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            err;

    logic [2:0]      state;
    logic [TW-1:0]   tick_cnt;
    logic            bit_end;
    logic [3:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            par;
    logic            txd;
    logic            done;
    logic [3:0]      cfg_bits;
    logic            cfg_par_en;
    logic            cfg_par_odd;
    logic            cfg_stop2;
    logic [3:0]      eff_bits;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop   = (state == IDLE) && TXen && !empty;
    assign push  = bus.wr_en_i && (!full || pop);

    assign bus.tx_full_o       = full;
    assign bus.tx_empty_o      = empty;
    assign bus.tx_level_o      = wr_ptr - rd_ptr;
    assign bus.error_tx_detect = err;

    // Out-of-range widths fall back to a full byte
    assign eff_bits = (number_data_send >= 4'd5 && number_data_send <= 4'd8)
                      ? number_data_send : 4'd8;

    assign bit_end   = baud_tick_i && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign UART_TXD  = txd;
    assign tx_busy_o = (state != IDLE);
    assign TXdone    = done;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            err <= bus.wr_en_i && full && !pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            txd         <= 1'b1;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par         <= 1'b0;
            done        <= 1'b0;
            cfg_bits    <= 4'd8;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_stop2   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                if (pop) begin
                    shift_reg   <= mem[rd_ptr[ADDR_W-1:0]];
                    cfg_bits    <= eff_bits;
                    cfg_par_en  <= parity_en_i;
                    cfg_par_odd <= parity_odd_i;
                    cfg_stop2   <= stop_bit_twice;
                    state       <= START;
                    txd         <= 1'b0;
                end
            end else if (baud_tick_i) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
                if (bit_end) begin
                    // txd is loaded with the value of the bit being entered
                    unique case (state)
                        START: begin
                            state   <= DATA;
                            txd     <= shift_reg[0];
                            bit_cnt <= '0;
                            par     <= 1'b0;
                        end
                        DATA: begin
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + 1'b1;
                            par       <= par ^ shift_reg[0];
                            if (bit_cnt == cfg_bits - 4'd1) begin
                                if (cfg_par_en) begin
                                    state <= PARITY;
                                    txd   <= par ^ shift_reg[0] ^ cfg_par_odd;
                                end else begin
                                    state <= STOP1;
                                    txd   <= 1'b1;
                                end
                            end else begin
                                txd <= shift_reg[1];
                            end
                        end
                        PARITY: begin
                            state <= STOP1;
                            txd   <= 1'b1;
                        end
                        STOP1: begin
                            txd <= 1'b1;
                            if (cfg_stop2) begin
                                state <= STOP2;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                        STOP2: begin
                            txd   <= 1'b1;
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                        default: begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit-side neighbour of the APB UART receive path. It buffers bytes written by the APB interface (write_data / tx_fifo_mid) in a small FIFO. It then serializes each byte onto UART_TXD as start bit, 5–8 data bits (LSB first), optional parity and 1 or 2 stop bits. Bit timing comes from the oversampled baud enable generated by the APB interface's clock divider. It reports TXdone and error_tx_detect back to the APB interface status logic.

Parameters:
DEPTH, 16, FIFO entries (power of 2)
ADDR_W, 4, log2(DEPTH)
OVERSAMPLE, 16, baud_tick_i pulses per UART bit

Ports:
clk_i  in  1  system clock; single clock domain
rst_ni  in  1  reset, synchronous, active-low
baud_tick_i  in  1  one-cycle oversample enable (16x baud)
TXen  in  1  transmit enable from custom_fsm_wr_rd
wr_en_i  in  1  push wr_data_i into FIFO
wr_data_i  in  8  byte to transmit
number_data_send  in  4  data bits per frame, 5..8
parity_en_i  in  1  1 = parity bit present
parity_odd_i  in  1  1 = odd parity, 0 = even
stop_bit_twice  in  1  1 = two stop bits
UART_TXD  out  1  serial line, idle high
tx_busy_o  out  1  frame in progress (state != IDLE)
tx_full_o  out  1  FIFO full
tx_empty_o  out  1  FIFO empty
tx_level_o  out  ADDR_W+1  FIFO occupancy 0..DEPTH
TXdone  out  1  one-cycle pulse at end of last stop bit
error_tx_detect  out  1  one-cycle pulse on write to full FIFO

Behaviour:
- Reset (rst_ni=0 at rising clk_i edge): UART_TXD=1, state=IDLE, FIFO pointers=0, tx_level_o=0, tx_empty_o=1, tx_full_o=0, tx_busy_o=0, TXdone=0, error_tx_detect=0. Reset mid-frame aborts the frame and releases the line high on the same edge. The partially sent byte is lost.
- FIFO: circular, ADDR_W+1-bit read and write pointers; wrap-around is natural overflow of the pointers.
  - Full: pointers differ only in MSB.
  - Empty: pointers are equal.
  - Push when wr_en_i && (!full || pop in same cycle).
  - wr_en_i while full with no pop: data dropped, pointers unchanged, error_tx_detect=1 for that cycle.
  - Push and pop in the same cycle: level unchanged.
  - A byte pushed into an empty FIFO is poppable on the following cycle, not the same one.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: if TXen && !empty, pop the head into shift_reg and latch the frame config (data count, parity_en, parity_odd, stop_bit_twice) → START. UART_TXD=0 from the next edge.
  - Config changes after the latch do not affect the current frame.
  - number_data_send outside 5..8 is treated as 8.
- Bit timing:
  - tick_cnt counts baud_tick_i pulses.
  - A bit ends on the cycle where baud_tick_i=1 and tick_cnt==OVERSAMPLE-1; tick_cnt then clears to 0.
  - tick_cnt clears on entry to START.
  - Each bit therefore lasts exactly OVERSAMPLE baud_tick_i pulses.
- START: drive 0 → DATA.
- DATA: drive shift_reg[0]. At bit end, shift right and increment bit_cnt. After the latched count of bits → PARITY if parity_en, else STOP1.
- PARITY: drive XOR of the transmitted data bits, inverted if parity_odd → STOP1.
- STOP1: drive 1. At bit end → STOP2 if stop_bit_twice, else finish.
- STOP2: drive 1. At bit end → finish.
- Finish: TXdone=1 for one clk_i cycle, state=IDLE.
  - If TXen && !empty in that same cycle, the IDLE pop happens on the next cycle, giving back-to-back frames with no added idle bit. The line stays high for that single clk_i cycle.
- TXen deassert mid-frame: the current frame completes normally, including TXdone. No new frame starts until TXen=1.
- baud_tick_i stalled: the FSM holds its state and the UART_TXD value indefinitely.
- UART_TXD is driven from a register; there is no combinational path from any input.

Test Plan:
- 8N1, push 0x55, TXen=1 → UART_TXD low for 16 ticks, then bits 1,0,1,0,1,0,1,0 each 16 ticks, then high 16 ticks. TXdone pulses once after 160 ticks; tx_empty_o=1.
- 7 bits, even parity, 2 stop, push 0xA3 → data bits 1,1,0,0,0,1,0 (bit7 ignored), parity=1, two stop bits. TXdone after 11×16=176 ticks. With parity_odd_i=1 the parity bit is 0.
- TXen=0, push 17 bytes 0x00..0x10 → tx_full_o=1 and tx_level_o=16 after the 16th push. The 17th push gives error_tx_detect=1 for one cycle. Enabling TXen then sends 0x00..0x0F in order, and the 16 frames run back-to-back.
- Full FIFO, TXen=1, wr_en_i asserted in the pop cycle → no error, level stays 16, new byte transmitted last.
- Frame of 0xFF in DATA bit 3, rst_ni=0 for 1 cycle → UART_TXD=1 at that edge, level=0, no TXdone. A subsequent push of 0x0F transmits correctly.
- Mid-frame change of stop_bit_twice 0→1 and number_data_send 8→5 → current frame keeps 8 data bits and 1 stop bit; the next frame uses 5 data bits and 2 stop bits.
